serializador_8bits: RTL and testbench
=====================================

Name: serializador_8bits

Overview:
Parallel-in/serial-out transmitter. It is the read-out counterpart of the 8-bit parallel D-register: it accepts a parallel word under a load/ready handshake and shifts it out one bit per clock. A frame/done strobe pair marks word boundaries. It sits between a parallel register bank and a single-wire serial link, or a matching serial-to-parallel receiver.

Parameters:
WIDTH, 8, word width in bits (≥2)
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous, active-high reset
d  input  WIDTH  parallel word to transmit
load  input  1  request: capture d on this edge if ready=1
ready  output  1  transmitter can accept a word this cycle
q  output  1  serial data out (registered)
qneg  output  1  always ~q
frame  output  1  high while q carries a valid data bit
done  output  1  one-cycle pulse during the last bit of a word

Behaviour:
- Interface: one clock (clk); clear is asynchronous and active-high, with no synchronizer inside the block.
- On clear: state=IDLE, shift register=0, bit counter=0, q=0, qneg=1, frame=0, done=0, ready=1. These values apply immediately, not at the next edge.
- States:
  - IDLE: ready=1, frame=0, q=0.
  - SHIFT: frame=1.
- ready = (state==IDLE) or (state==SHIFT and counter==WIDTH-1). ready is combinational from registered state.
- Handshake: a transfer occurs on a rising edge where load=1 and ready=1. load is ignored when ready=0: d is not sampled and there is no error flag.
- Latency: the first bit appears on q in the cycle after the accepting edge. Bit k (k=0..WIDTH-1) appears k+1 cycles after that edge.
- Ordering:
  - LSB_FIRST=1: d[0], d[1], …, d[WIDTH-1].
  - LSB_FIRST=0: d[WIDTH-1] … d[0].
- Counter: width clog2(WIDTH). It is 0 on the first bit, increments every SHIFT cycle, and wraps to 0 on a new load. It never exceeds WIDTH-1.
- done=1 exactly in the cycle counter==WIDTH-1 (last bit on q). Otherwise done=0.
- End of word (edge leaving the last-bit cycle):
  - load=1: capture the new d, stay in SHIFT, counter=0. The next word's first bit follows with no gap and frame stays high.
  - load=0: go to IDLE, q=0, frame=0.
- A word is always sent in full once accepted; no abort except clear.
- clear mid-frame drops the remaining bits. After clear deasserts, the block is in IDLE and accepts a load on the next edge.
- d may change freely after the accepting edge, because the word is held internally.

Decomposition:
- Shared header serializador_defs.vh holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - default WIDTH;
  - the LSB_FIRST encoding.
- One natural sub-module: contador_bits, a modulo-WIDTH up-counter with synchronous load-to-zero, increment enable, terminal-count output and async active-high clear. It is reused later by the receiver.
- The shift register and FSM live in the top module.

Test Plan:
- Reset values: assert clear mid-cycle → q=0, qneg=1, frame=0, done=0, ready=1 immediately. Hold load=1 during clear → nothing is captured.
- Single word: LSB_FIRST=1, d=8'hA5, load for one edge → q=1,0,1,0,0,1,0,1 over cycles 1–8 and frame=1 for exactly 8 cycles. done is high only in cycle 8, ready is low in cycles 1–7 and high in cycle 8, then q=0 and frame=0.
- Back-to-back: 8'hA5 then 8'h3C, with load asserted in the done cycle → 16 contiguous bits 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. frame never drops and done pulses in cycles 8 and 16.
- Load while busy: load=1 with d=8'hFF during cycles 2–7 of an 8'h00 transfer → q stays 0 for all 8 bits, and the block returns to IDLE after cycle 8.
- MSB-first: LSB_FIRST=0, d=8'h81 → q=1,0,0,0,0,0,0,1; d=8'h80 → 1 followed by seven 0s.
- Clear mid-frame: d=8'hFF, pulse clear during bit 3 → q drops to 0 at once and the remaining bits are not sent. A following load of 8'h01 sends 1,0,0,0,0,0,0,0 with done in its cycle 8.

Source files
------------

// File: rtl/serializador_8bits_pkg.sv
// Shared definitions for the serializer and its companion receiver:
// FSM state encoding, default word width and bit-order encoding.
package serializador_8bits_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam bit LSB_FIRST_ON = 1'b1;
   localparam bit MSB_FIRST_ON = 1'b0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/serializador_8bits_contador_bits.sv
// Modulo-WIDTH up-counter with synchronous zero, increment enable,
// terminal-count flag and asynchronous active-high clear.
module contador_bits
   import serializador_8bits_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          zero,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc
);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   assign tc    = (count_reg == CW'(WIDTH - 1));
   assign count = count_reg;

   // zero wins over en so a fresh word always starts at bit 0
   always_comb begin
      count_next = count_reg;
      if (zero) begin
         count_next = '0;
      end else if (en) begin
         count_next = tc ? '0 : count_reg + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/serializador_8bits.sv
// Parallel-in/serial-out transmitter with load/ready handshake and
// frame/done word-boundary strobes; registered serial output.
module serializador_8bits
   import serializador_8bits_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = LSB_FIRST_ON,
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   output logic             ready,
   output logic             q,
   output logic             qneg,
   output logic             frame,
   output logic             done
);

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_next;
   logic             q_reg;
   logic             q_next;
   logic [WIDTH-1:0] d_ord;
   logic [CW-1:0]    bit_cnt;
   logic             bit_tc;
   logic             accept;

   // Reorder the word once so the shifter always sends bit 0 next
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
         if (LSB_FIRST == LSB_FIRST_ON) begin : g_lsb
            assign d_ord[gi] = d[gi];
         end else begin : g_msb
            assign d_ord[gi] = d[WIDTH-1-gi];
         end
      end
   endgenerate

   contador_bits #(
      .WIDTH (WIDTH)
   ) u_contador (
      .clk   (clk),
      .clear (clear),
      .zero  (accept),
      .en    (state_reg == ST_SHIFT),
      .count (bit_cnt),
      .tc    (bit_tc)
   );

   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      q_next     = q_reg;
      ready      = 1'b0;
      case (state_reg)
         ST_IDLE:  ready = 1'b1;
         ST_SHIFT: ready = bit_tc;
         default:  ready = 1'b0;
      endcase
      accept = load && ready;
      if (accept) begin
         state_next = ST_SHIFT;
         q_next     = d_ord[0];
         shift_next = d_ord >> 1;
      end else if (state_reg == ST_SHIFT) begin
         if (bit_tc) begin
            state_next = ST_IDLE;
            q_next     = 1'b0;
            shift_next = '0;
         end else begin
            q_next     = shift_reg[0];
            shift_next = shift_reg >> 1;
         end
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_reg <= ST_IDLE;
         shift_reg <= '0;
         q_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         q_reg     <= q_next;
      end
   end

   assign q     = q_reg;
   assign qneg  = ~q_reg;
   assign frame = (state_reg == ST_SHIFT);
   assign done  = frame && (bit_cnt == CW'(WIDTH - 1));

endmodule

// File: tb/tb_serializador_8bits.sv
// Bench for serializador_8bits: an LSB-first and an MSB-first instance
// checked every cycle against a queue-of-bits reference model.
module tb_serializador_8bits;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         clear = 1'b0;
   logic [W-1:0] d_l = '0, d_m = '0;
   logic         load_l = 1'b0, load_m = 1'b0;
   logic         ready_l, q_l, qneg_l, frame_l, done_l;
   logic         ready_m, q_m, qneg_m, frame_m, done_m;

   int n_cmp = 0;
   int n_err = 0;

   logic [63:0] hist_l = '0, hist_m = '0;

   // Reference model: bit on the wire now, plus the bits still to go
   bit m_valid[2];
   bit m_cur[2];
   bit rem_l[$];
   bit rem_m[$];

   always #5 clk = ~clk;

   serializador_8bits #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
      .clk(clk), .clear(clear), .d(d_l), .load(load_l),
      .ready(ready_l), .q(q_l), .qneg(qneg_l), .frame(frame_l), .done(done_l)
   );

   serializador_8bits #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
      .clk(clk), .clear(clear), .d(d_m), .load(load_m),
      .ready(ready_m), .q(q_m), .qneg(qneg_m), .frame(frame_m), .done(done_m)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int u = 0; u < 2; u++) begin
         m_valid[u] = 1'b0;
         m_cur[u]   = 1'b0;
      end
      rem_l.delete();
      rem_m.delete();
   endfunction

   function automatic int rem_size(input int u);
      return (u == 0) ? rem_l.size() : rem_m.size();
   endfunction

   function automatic bit model_edge(input int u, input bit ld, input logic [W-1:0] dv,
                                     input bit lsb);
      bit tmp[$];
      bit rdy;
      bit acc;
      tmp = (u == 0) ? rem_l : rem_m;
      rdy = !m_valid[u] || (tmp.size() == 0);
      acc = ld && rdy;
      if (acc) begin
         tmp.delete();
         for (int i = 0; i < W; i++) tmp.push_back(lsb ? dv[i] : dv[W-1-i]);
      end
      if (tmp.size() > 0) begin
         m_cur[u]   = tmp.pop_front();
         m_valid[u] = 1'b1;
      end else begin
         m_cur[u]   = 1'b0;
         m_valid[u] = 1'b0;
      end
      if (u == 0) rem_l = tmp;
      else        rem_m = tmp;
      return acc;
   endfunction

   task automatic check_unit(input string nm, input int u, input logic q, input logic qneg,
                             input logic frame, input logic done, input logic ready);
      bit eq;
      eq = m_valid[u] ? m_cur[u] : 1'b0;
      chk({nm, "_q"},     32'(q),     32'(eq));
      chk({nm, "_qneg"},  32'(qneg),  32'(!eq));
      chk({nm, "_frame"}, 32'(frame), 32'(m_valid[u]));
      chk({nm, "_done"},  32'(done),  32'(m_valid[u] && rem_size(u) == 0));
      chk({nm, "_ready"}, 32'(ready), 32'(!m_valid[u] || rem_size(u) == 0));
   endtask

   task automatic check_all();
      check_unit("lsb", 0, q_l, qneg_l, frame_l, done_l, ready_l);
      check_unit("msb", 1, q_m, qneg_m, frame_m, done_m, ready_m);
   endtask

   task automatic cycle(input bit ll, input logic [W-1:0] dl, input bit lm,
                        input logic [W-1:0] dm);
      bit acc;
      load_l = ll; d_l = dl;
      load_m = lm; d_m = dm;
      @(posedge clk);
      if (clear) begin
         model_reset();
      end else begin
         acc = model_edge(0, ll, dl, 1'b1);
         if (acc) $display("[%0t] lsb accepted d=%h", $time, dl);
         acc = model_edge(1, lm, dm, 1'b0);
         if (acc) $display("[%0t] msb accepted d=%h", $time, dm);
      end
      #1;
      hist_l = {hist_l[62:0], q_l};
      hist_m = {hist_m[62:0], q_m};
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0);
   endtask

   initial begin
      model_reset();
      // Asynchronous clear before any clock edge
      #2 clear = 1'b1;
      #1 check_all();
      // load held through an edge while clear is high: nothing captured
      cycle(1'b1, 8'hFF, 1'b1, 8'hFF);
      #2 clear = 1'b0;
      idle(1);

      // Single word: A5 LSB-first, 81 MSB-first
      cycle(1'b1, 8'hA5, 1'b1, 8'h81);
      idle(7);
      chk("seq_a5_lsb", 32'(hist_l[7:0]), 32'h000000A5);
      chk("seq_81_msb", 32'(hist_m[7:0]), 32'h00000081);
      idle(1);
      chk("idle_after_word_frame", 32'(frame_l), 32'd0);

      // Back-to-back words with load in the done cycle
      cycle(1'b1, 8'hA5, 1'b1, 8'h80);
      idle(7);
      cycle(1'b1, 8'h3C, 1'b1, 8'h81);
      idle(7);
      chk("seq_b2b_lsb", 32'(hist_l[15:0]), 32'h0000A53C);
      chk("seq_b2b_msb", 32'(hist_m[15:0]), 32'h00008081);
      idle(1);

      // Load while busy is ignored
      cycle(1'b1, 8'h00, 1'b1, 8'h00);
      idle(1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'hFF, 1'b1, 8'hFF);
      chk("busy_seq_lsb", 32'(hist_l[7:0]), 32'h00000000);
      cycle(1'b0, '0, 1'b0, '0);
      chk("busy_back_idle", 32'(ready_l && !frame_l), 32'd1);

      // Clear during bit 3 of an FF word
      cycle(1'b1, 8'hFF, 1'b1, 8'hFF);
      idle(2);
      #2 clear = 1'b1;
      model_reset();
      #1 check_all();
      cycle(1'b1, 8'hAA, 1'b1, 8'hAA);
      #2 clear = 1'b0;
      cycle(1'b1, 8'h01, 1'b1, 8'h01);
      idle(7);
      chk("seq_01_lsb", 32'(hist_l[7:0]), 32'h00000080);
      chk("seq_01_msb", 32'(hist_m[7:0]), 32'h00000001);
      idle(1);

      // Randomized traffic with occasional asynchronous clears
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 2) == 0, W'($urandom), $urandom_range(0, 1) == 0, W'($urandom));
         if ($urandom_range(0, 199) == 0) begin
            #2 clear = 1'b1;
            model_reset();
            #1 check_all();
            #1 clear = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
